// File: rtl/fp16_pkg.sv
// Shared binary16 definitions: field layout, bias, special exponent, flag bit
// positions and operand classification, common to the FP16 converter and adder.
package fp16_pkg;

  localparam int FP16_W   = 16;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  // Out_flags layout: {invalid, inexact}
  localparam int FLAG_INVALID = 1;
  localparam int FLAG_INEXACT = 0;

  // Magnitude of the largest finite binary16 fits in 16 integer bits; 24
  // fraction bits hold the smallest subnormal step (2^-24) exactly.
  localparam int MAG_W  = 16;
  localparam int FRAC_W = EXP_BIAS + MANT_W - 1;
  localparam int FIX_W  = MAG_W + FRAC_W;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  function automatic cls_t fp16_classify(input fp16_t op);
    if (op.exp != EXP_ALL_ONES) return CLS_NUM;
    else if (op.mant == '0)     return CLS_INF;
    else                        return CLS_NAN;
  endfunction

endpackage

// File: rtl/fp16_int_round_sat.sv
// Combinational second stage: round-to-nearest-even, negate and saturate to INT_W.
// Flag outputs exist only when FP16_CVT_FLAGS_EN is defined.
module fp16_int_round_sat
  import fp16_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic             sign,
  input  cls_t             cls,
  input  logic [MAG_W-1:0] int_mag,
  input  logic             guard_bit,
  input  logic             round_bit,
  input  logic             sticky_bit,
  output logic [INT_W-1:0] res
`ifdef FP16_CVT_FLAGS_EN
  ,
  output logic [1:0]       flags
`endif
);

  localparam logic [32:0] POS_MAX = 33'((64'd1 << (INT_W - 1)) - 64'd1);
  localparam logic [32:0] NEG_MAG = 33'(64'd1 << (INT_W - 1));
  localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};

  logic             round_up;
  logic [MAG_W:0]   mag_r;
  logic [32:0]      mag_ext;
  logic [INT_W-1:0] mag_int;
  logic             pos_ovf;
  logic             neg_ovf;

  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    round_up = guard_bit & (round_bit | sticky_bit | int_mag[0]);
    mag_r    = {1'b0, int_mag} + (MAG_W+1)'(round_up);
    mag_ext  = 33'(mag_r);
    mag_int  = INT_W'(mag_r);
    pos_ovf  = !sign && (mag_ext > POS_MAX);
    neg_ovf  =  sign && (mag_ext > NEG_MAG);
    res      = sign ? -mag_int : mag_int;

    unique case (cls)
      CLS_INF: res = sign ? SAT_NEG : SAT_POS;
      CLS_NAN: res = '0;
      default: begin
        if (pos_ovf)      res = SAT_POS;
        else if (neg_ovf) res = SAT_NEG;
      end
    endcase
  end

`ifdef FP16_CVT_FLAGS_EN
  logic invalid;

  always_comb begin
    invalid             = (cls != CLS_NUM) || pos_ovf || neg_ovf;
    flags               = '0;
    flags[FLAG_INVALID] = invalid;
    flags[FLAG_INEXACT] = (guard_bit | round_bit | sticky_bit) & !invalid;
  end
`endif

endmodule

// File: rtl/fp16_to_int_cvt.sv
// Two-stage binary16 to signed INT_W converter with valid/ready handshake.
// Define FP16_CVT_FLAGS_EN to add the {invalid, inexact} out_flags port.
module fp16_to_int_cvt
  import fp16_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  out_data
`ifdef FP16_CVT_FLAGS_EN
  ,
  output logic [1:0]        out_flags
`endif
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 combinational: unpack, classify and align into fixed point.
  fp16_t            op;
  logic [MANT_W:0]  sig;
  logic [EXP_W-1:0] shamt;
  logic [FIX_W-1:0] fixed;

  always_comb begin
    op    = fp16_t'(in_data);
    sig   = {(op.exp != '0), op.mant};
    // Subnormals share the exponent-1 scale with an implicit leading zero.
    shamt = (op.exp == '0) ? '0 : op.exp - EXP_W'(1);
    fixed = {{(FIX_W-MANT_W-1){1'b0}}, sig} << shamt;
  end

  logic             s1_valid;
  logic             s1_sign;
  cls_t             s1_cls;
  logic [MAG_W-1:0] s1_mag;
  logic             s1_guard;
  logic             s1_round;
  logic             s1_sticky;

  // NOTE: the S1 payload carries no reset; it is only consumed alongside
  // s1_valid, which is reset, so clearing it would add nothing.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_sign   <= op.sign;
      s1_cls    <= fp16_classify(op);
      s1_mag    <= fixed[FIX_W-1 -: MAG_W];
      s1_guard  <= fixed[FRAC_W-1];
      s1_round  <= fixed[FRAC_W-2];
      s1_sticky <= |fixed[FRAC_W-3:0];
    end
  end

  logic [INT_W-1:0] s2_res;
`ifdef FP16_CVT_FLAGS_EN
  logic [1:0]       s2_flags;
`endif

  fp16_int_round_sat #(.INT_W(INT_W)) u_round_sat (
    .sign       (s1_sign),
    .cls        (s1_cls),
    .int_mag    (s1_mag),
    .guard_bit  (s1_guard),
    .round_bit  (s1_round),
    .sticky_bit (s1_sticky),
    .res        (s2_res)
`ifdef FP16_CVT_FLAGS_EN
    ,
    .flags      (s2_flags)
`endif
  );

  // NOTE: state uses non-blocking assignments and an asynchronous reset in
  // the sensitivity list so rst clears the pipe without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FP16_CVT_FLAGS_EN
      out_flags <= '0;
`endif
    end else if (adv) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= s2_res;
`ifdef FP16_CVT_FLAGS_EN
        out_flags <= s2_flags;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp16_to_int_cvt.sv
// Directed self-checking bench for fp16_to_int_cvt (INT_W=16): vector table
// plus throughput, backpressure and mid-flight reset sequences.
module tb_fp16_to_int_cvt;

  localparam int INT_W = 16;
  localparam int NV    = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] out_data;
`ifdef FP16_CVT_FLAGS_EN
  logic [1:0]       out_flags;
`endif

  always #5 clk = ~clk;

  fp16_to_int_cvt #(.INT_W(INT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP16_CVT_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0]  flags;   // {invalid, inexact}
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v.din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("latency_%04h", v.din), 32'(out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("valid_%04h", v.din), 32'(out_valid), 32'd1);
    check($sformatf("data_%04h", v.din), 32'(out_data), 32'(v.dout));
`ifdef FP16_CVT_FLAGS_EN
    check($sformatf("flags_%04h", v.din), 32'(out_flags), 32'(v.flags));
`endif
  endtask

  logic [15:0] seq_in [8];

  initial begin
    vecs[0]  = '{16'h3C00, 16'h0001, 2'b00};  // 1.0
    vecs[1]  = '{16'h3800, 16'h0000, 2'b01};  // 0.5 ties to even 0
    vecs[2]  = '{16'h3E00, 16'h0002, 2'b01};  // 1.5 -> 2
    vecs[3]  = '{16'h4100, 16'h0002, 2'b01};  // 2.5 -> 2
    vecs[4]  = '{16'hC500, 16'hFFFB, 2'b00};  // -5
    vecs[5]  = '{16'h8000, 16'h0000, 2'b00};  // -0
    vecs[6]  = '{16'hF800, 16'h8000, 2'b00};  // -32768 in range
    vecs[7]  = '{16'h7BFF, 16'h7FFF, 2'b10};  // 65504 overflow
    vecs[8]  = '{16'hFC00, 16'h8000, 2'b10};  // -inf
    vecs[9]  = '{16'h7E00, 16'h0000, 2'b10};  // qNaN
    vecs[10] = '{16'h0001, 16'h0000, 2'b01};  // min subnormal
    vecs[11] = '{16'h7C00, 16'h7FFF, 2'b10};  // +inf
    vecs[12] = '{16'hFE00, 16'h0000, 2'b10};  // negative NaN
    vecs[13] = '{16'h7800, 16'h7FFF, 2'b10};  // +32768 overflow
    vecs[14] = '{16'hF801, 16'h8000, 2'b10};  // -32800 overflow
    vecs[15] = '{16'h4300, 16'h0004, 2'b01};  // 3.5 -> 4
    vecs[16] = '{16'h3A00, 16'h0001, 2'b01};  // 0.75 -> 1
    vecs[17] = '{16'hBA00, 16'hFFFF, 2'b01};  // -0.75 -> -1
    vecs[18] = '{16'hB800, 16'h0000, 2'b01};  // -0.5 -> -0 -> 0
    vecs[19] = '{16'h3C01, 16'h0001, 2'b01};  // 1.000977 sticky only

    seq_in = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
               16'h4500, 16'h4600, 16'h4700, 16'h4800};  // 1..8

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);
`ifdef FP16_CVT_FLAGS_EN
    check("reset_out_flags", 32'(out_flags), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Throughput: 8 back-to-back operands, results on consecutive cycles.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = seq_in[0];
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k + 1 < 8) in_data = seq_in[k+1];
      else           in_valid = 1'b0;
      @(negedge clk);
      if (k >= 1 && k <= 8) begin
        check($sformatf("tput_valid_%0d", k), 32'(out_valid), 32'd1);
        check($sformatf("tput_data_%0d", k),  32'(out_data),  32'(k));
      end else begin
        check($sformatf("tput_idle_%0d", k), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: fill both stages, stall three cycles, release.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'h4900;                 // 10
    @(posedge clk); #1;
    in_data  = 16'h4980;                 // 11
    @(posedge clk); #1;
    in_data  = 16'h4A00;                 // 12, held while stalled
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", k),  32'(in_ready),  32'd0);
      check($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_out_data_%0d", k),  32'(out_data),  32'd10);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_rel_data_b", 32'(out_data), 32'd11);
    check("bp_rel_valid_b", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_rel_data_c", 32'(out_data), 32'd12);
    check("bp_rel_valid_c", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset with two operands in flight, asserted between clock edges.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'h4500;
    @(posedge clk); #1;
    in_data  = 16'h4600;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_out_data",  32'(out_data),  32'd0);
    check("rst_async_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_stale_%0d", k), 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_to_int_cvt.md
FP16_TO_INT_CVT -- requirements
Module: fp16_to_int_cvt

Interface
REQ-001 SHALL have parameter INT_W, default 16, giving the signed two's-complement output width; legal range 8..32.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data holds an operand.
REQ-005 SHALL have port in_ready  output  1  block accepts the operand this cycle.
REQ-006 SHALL have port in_data  input  16  IEEE-754 binary16 operand {sign, exp[4:0], mant[9:0]}.
REQ-007 SHALL have port out_valid  output  1  out_data holds a result.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port out_data  output  INT_W  signed integer result.
REQ-010 SHALL have port out_flags  output  2  {invalid, inexact}; present only under the configuration macro.

Function
REQ-011 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready, at the rising edge.
REQ-012 SHALL implement a 2-stage pipeline: S1 unpack/classify/align, S2 round/negate/saturate; an accepted operand appears on out_data exactly 2 cycles later when there is no stall.
REQ-013 SHALL use one advance enable adv = !out_valid || out_ready; in_ready = adv (combinational, no dependence on in_valid).
REQ-014 SHALL sustain one result per cycle with out_ready held high; when adv=0, both stages and out_data/out_flags SHALL hold their values unchanged.
REQ-015 SHALL propagate bubbles: an S1 slot without a valid operand SHALL produce out_valid=0 when it advances.
REQ-016 SHALL compute magnitude = 1.mant * 2^(exp-15) for exp 1..30 and 0.mant * 2^-14 for exp 0, rounded to an integer using round-to-nearest-even on guard, round and sticky bits.
REQ-017 SHALL produce 0 for +0, -0 and all subnormals; a nonzero subnormal SHALL set inexact.
REQ-018 SHALL negate the rounded magnitude when sign=1; a result of -0 SHALL be output as 0.
REQ-019 SHALL saturate a positive overflow (including rounding-induced overflow) to 2^(INT_W-1)-1 and a negative overflow to -2^(INT_W-1), and SHALL set invalid in both cases.
REQ-020 SHALL accept -2^(INT_W-1) exactly as in range, with no invalid flag.
REQ-021 SHALL map +inf to the positive saturation value and -inf to the negative saturation value, with invalid set.
REQ-022 SHALL map NaN (exp=31, mant!=0) to 0 with invalid set, regardless of sign.
REQ-023 SHALL set inexact iff any discarded fraction bit is nonzero and invalid is clear.

Reset
REQ-024 SHALL, on rst assertion, immediately clear out_valid, out_data, out_flags and both stage valid bits to 0, without waiting for clk; in_ready SHALL then be 1.
REQ-025 SHALL discard any operands in flight when rst is asserted mid-operation; no result SHALL emerge for them after reset is released.

Configuration
REQ-026 SHALL support macro FP16_CVT_FLAGS_EN: when defined, the out_flags port and the flag logic are present and behave per REQ-019..023.
REQ-027 SHALL, when FP16_CVT_FLAGS_EN is undefined, omit the out_flags port and the flag logic; out_data behaviour SHALL be unchanged.

Structure
REQ-028 SHALL take the FP16 field widths, the exponent bias (15), the exponent-all-ones value and the flag bit indices from the shared fp16 package, shared with the adder.
REQ-029 SHALL place the S2 round-nearest-even plus saturation logic in the combinational sub-module fp16_int_round_sat; the pipeline registers and handshake SHALL stay in the top level.

Verification
REQ-030 SHALL cover rounding: 0x3C00 -> 1 {0,0}; 0x3800 (0.5) -> 0 {0,1}; 0x3E00 (1.5) -> 2 {0,1}; 0x4100 (2.5) -> 2 {0,1}.
REQ-031 SHALL cover sign handling: 0xC500 (-5.0) -> 0xFFFB {0,0}; 0x8000 -> 0 {0,0}; 0xF800 (-32768) -> 0x8000 {0,0} with INT_W=16.
REQ-032 SHALL cover specials with INT_W=16: 0x7BFF (65504) -> 0x7FFF {1,0}; 0xFC00 -> 0x8000 {1,0}; 0x7E00 -> 0 {1,0}; 0x0001 -> 0 {0,1}.
REQ-033 SHALL cover throughput: 8 back-to-back operands with out_ready=1 -> first out_valid 2 cycles after the first accept, then 8 consecutive results in order.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles with the pipe full -> in_ready=0, out_data stable, no loss or duplication after release.
REQ-035 SHALL cover reset with 2 operands in flight: rst pulse -> out_valid=0 immediately, and no stale result after release.
